// File: rtl/cp0_ctrl.sv
// +----------------------------------------------------------------------------+
// | cp0_ctrl : MIPS32 coprocessor-0 with Count/Compare timer, masked hardware  |
// |            interrupts and prioritised exception / ERET redirect.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module cp0_ctrl #(
  parameter int          NUM_HW_INT = 6,
  parameter int          COUNT_DIV  = 1,
  parameter logic [31:0] STATUS_RST = 32'h1000_0000,
  parameter logic [31:0] EBASE_RST  = 32'h8000_0000,
  parameter logic [31:0] EXC_OFFSET = 32'h0000_0180
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            raddr,
  output logic [31:0]           rdata,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [31:0]           wdata,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  exc_badv_we,
  input  logic                  eret,
  output logic                  int_req,
  output logic                  redirect,
  output logic [31:0]           redirect_pc,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  localparam logic [4:0]  c_REG_BADV   = 5'd8;
  localparam logic [4:0]  c_REG_COUNT  = 5'd9;
  localparam logic [4:0]  c_REG_CMP    = 5'd11;
  localparam logic [4:0]  c_REG_STATUS = 5'd12;
  localparam logic [4:0]  c_REG_CAUSE  = 5'd13;
  localparam logic [4:0]  c_REG_EPC    = 5'd14;
  localparam logic [4:0]  c_REG_EBASE  = 5'd15;
  localparam logic [31:0] c_STATUS_WMASK = 32'h0000_FF03;

  logic [31:0]           r_badvaddr;
  logic [31:0]           r_count;
  logic [31:0]           r_compare;
  logic [31:0]           r_status;
  logic [31:0]           r_epc;
  logic [17:0]           r_ebase;
  logic                  r_bd;
  logic [4:0]            r_exccode;
  logic [1:0]            r_sw;
  logic [NUM_HW_INT-1:0] r_hw;
  logic                  r_ti;
  logic                  r_div;
  logic                  r_redirect;
  logic [31:0]           r_redirect_pc;

  logic                  w_eret;
  logic                  w_mtc0;
  logic                  w_tick;
  logic                  w_match;
  logic [5:0]            w_hw_ext;
  logic [7:0]            w_ip;
  logic [31:0]           w_cause;
  logic [31:0]           w_ebase;

  generate
    if (NUM_HW_INT < 6) begin : g_hw_pad
      assign w_hw_ext = {{(6 - NUM_HW_INT){1'b0}}, r_hw};
    end else begin : g_hw_full
      assign w_hw_ext = r_hw;
    end
  endgenerate

  // IP7 is shared between the timer and the sixth hardware line
  assign w_ip    = {r_ti | w_hw_ext[5], w_hw_ext[4:0], r_sw};
  assign w_cause = {r_bd, 15'b0, w_ip, 1'b0, r_exccode, 2'b0};
  assign w_ebase = {2'b10, r_ebase, 12'b0};

  // exception outranks ERET, which outranks MTC0
  assign w_eret  = eret & ~exc_valid;
  assign w_mtc0  = we & ~exc_valid & ~eret;
  assign w_tick  = (COUNT_DIV == 1) ? 1'b1 : r_div;
  assign w_match = (r_count == r_compare) && (r_compare != 32'd0);

  assign int_req = r_status[0] & ~r_status[1] & |(w_ip & r_status[15:8]);

  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign status_o    = r_status;
  assign cause_o     = w_cause;
  assign epc_o       = r_epc;

  always_comb begin
    rdata = 32'd0;
    case (raddr)
      c_REG_BADV:   rdata = r_badvaddr;
      c_REG_COUNT:  rdata = r_count;
      c_REG_CMP:    rdata = r_compare;
      c_REG_STATUS: rdata = r_status;
      c_REG_CAUSE:  rdata = w_cause;
      c_REG_EPC:    rdata = r_epc;
      c_REG_EBASE:  rdata = w_ebase;
      default:      rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_badvaddr    <= 32'd0;
      r_count       <= 32'd0;
      r_compare     <= 32'd0;
      r_status      <= STATUS_RST;
      r_epc         <= 32'd0;
      r_ebase       <= EBASE_RST[29:12];
      r_bd          <= 1'b0;
      r_exccode     <= 5'd0;
      r_sw          <= 2'b00;
      r_hw          <= '0;
      r_ti          <= 1'b0;
      r_div         <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= 32'd0;
    end else begin
      r_hw       <= hw_int;
      r_redirect <= 1'b0;

      if (w_mtc0 && waddr == c_REG_COUNT) begin
        r_count <= wdata;
        r_div   <= 1'b0;
      end else begin
        if (w_tick) r_count <= r_count + 32'd1;
        r_div <= ~r_div;
      end

      if (w_mtc0 && waddr == c_REG_CMP) r_ti <= 1'b0;
      else if (w_match)                 r_ti <= 1'b1;

      if (exc_valid) begin
        if (!r_status[1]) begin
          r_epc <= exc_bd ? exc_pc - 32'd4 : exc_pc;
          r_bd  <= exc_bd;
        end
        r_status[1]   <= 1'b1;
        r_exccode     <= exc_code;
        if (exc_badv_we) r_badvaddr <= exc_badvaddr;
        r_redirect    <= 1'b1;
        r_redirect_pc <= w_ebase + EXC_OFFSET;
      end else if (w_eret) begin
        r_status[1]   <= 1'b0;
        r_redirect    <= 1'b1;
        r_redirect_pc <= r_epc;
      end else if (w_mtc0) begin
        case (waddr)
          c_REG_CMP:    r_compare <= wdata;
          c_REG_STATUS: r_status  <= (r_status & ~c_STATUS_WMASK) | (wdata & c_STATUS_WMASK);
          c_REG_CAUSE:  r_sw      <= wdata[9:8];
          c_REG_EPC:    r_epc     <= wdata;
          c_REG_EBASE:  r_ebase   <= wdata[29:12];
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cp0_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_cp0_ctrl : directed self-checking bench for cp0_ctrl.                   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [5:0]  hw_int;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic        exc_badv_we;
  logic        eret;
  logic        int_req;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] status_o;
  logic [31:0] cause_o;
  logic [31:0] epc_o;

  int checks = 0;
  int errors = 0;

  cp0_ctrl dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata),
    .we(we), .waddr(waddr), .wdata(wdata), .hw_int(hw_int),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_badvaddr(exc_badvaddr), .exc_badv_we(exc_badv_we), .eret(eret),
    .int_req(int_req), .redirect(redirect), .redirect_pc(redirect_pc),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o)
  );

  always #5 clk = ~clk;

  // advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    raddr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b0; raddr = 5'd0; we = 1'b0; waddr = 5'd0; wdata = 32'd0; hw_int = 6'd0;
    exc_valid = 1'b0; exc_code = 5'd0; exc_pc = 32'd0; exc_bd = 1'b0;
    exc_badvaddr = 32'd0; exc_badv_we = 1'b0; eret = 1'b0;
    tick(); tick();
    rst = 1'b1;

    // reset values
    rd(5'd12, "status_rst", 32'h1000_0000);
    rd(5'd13, "cause_rst",  32'h0000_0000);
    rd(5'd15, "ebase_rst",  32'h8000_0000);
    rd(5'd9,  "count_rst",  32'd0);
    check("redirect_rst", {31'd0, redirect}, 32'd0);
    tick(); tick(); tick();
    rd(5'd9, "count_3", 32'd3);
    rd(5'd10, "unimpl_rd", 32'd0);

    // Count/Compare timer
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd5);
    rd(5'd9, "count_load", 32'd5);
    repeat (5) tick();
    rd(5'd9, "count_10", 32'd10);
    check("ti_not_yet", {31'd0, cause_o[15]}, 32'd0);
    tick();
    rd(5'd9, "count_11", 32'd11);
    check("ti_set", {31'd0, cause_o[15]}, 32'd1);
    tick();
    check("ti_sticky", {31'd0, cause_o[15]}, 32'd1);
    mtc0(5'd11, 32'd20);
    check("ti_clear", {31'd0, cause_o[15]}, 32'd0);

    // hardware interrupt
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, "status_wr", 32'h1000_0401);
    hw_int = 6'b000001;
    #1;
    check("ip2_latency", {31'd0, cause_o[10]}, 32'd0);
    tick();
    check("ip2_set", {31'd0, cause_o[10]}, 32'd1);
    check("int_req_on", {31'd0, int_req}, 32'd1);
    mtc0(5'd12, 32'h0000_0403);
    check("int_req_exl", {31'd0, int_req}, 32'd0);
    hw_int = 6'd0;
    mtc0(5'd12, 32'h0000_0401);
    check("ip2_clear", {31'd0, cause_o[10]}, 32'd0);

    // exception in delay slot
    exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h8000_0104; exc_bd = 1'b1;
    exc_badvaddr = 32'h0000_1234; exc_badv_we = 1'b1;
    tick();
    check("exc_epc", epc_o, 32'h8000_0100);
    check("exc_bd", {31'd0, cause_o[31]}, 32'd1);
    check("exc_code", {27'd0, cause_o[6:2]}, 32'd8);
    check("exc_exl", {31'd0, status_o[1]}, 32'd1);
    check("exc_redir", {31'd0, redirect}, 32'd1);
    check("exc_vec", redirect_pc, 32'h8000_0180);
    rd(5'd8, "badvaddr", 32'h0000_1234);
    // nested exception with EXL set
    exc_code = 5'd4; exc_pc = 32'h8000_0200; exc_bd = 1'b0; exc_badv_we = 1'b0;
    tick();
    exc_valid = 1'b0;
    check("nest_epc", epc_o, 32'h8000_0100);
    check("nest_bd", {31'd0, cause_o[31]}, 32'd1);
    check("nest_code", {27'd0, cause_o[6:2]}, 32'd4);
    tick();
    check("redir_drop", {31'd0, redirect}, 32'd0);

    // ERET
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("eret_redir", {31'd0, redirect}, 32'd1);
    check("eret_pc", redirect_pc, 32'h8000_0100);
    check("eret_exl", {31'd0, status_o[1]}, 32'd0);

    // exception + eret + MTC0 EPC together
    exc_valid = 1'b1; exc_code = 5'd12; exc_pc = 32'h8000_0300; exc_bd = 1'b0;
    eret = 1'b1; we = 1'b1; waddr = 5'd14; wdata = 32'hDEAD_BEEF;
    tick();
    exc_valid = 1'b0; eret = 1'b0; we = 1'b0;
    check("prio_epc", epc_o, 32'h8000_0300);
    check("prio_pc", redirect_pc, 32'h8000_0180);
    check("prio_exl", {31'd0, status_o[1]}, 32'd1);

    // reset with TI set and redirect pending
    mtc0(5'd11, 32'd100);
    mtc0(5'd9, 32'd100);
    exc_valid = 1'b1; exc_code = 5'd0; exc_pc = 32'h8000_0400;
    tick();
    exc_valid = 1'b0;
    check("pre_rst_ti", {31'd0, cause_o[15]}, 32'd1);
    check("pre_rst_redir", {31'd0, redirect}, 32'd1);
    rst = 1'b0;
    tick();
    check("rst_redir", {31'd0, redirect}, 32'd0);
    check("rst_status", status_o, 32'h1000_0000);
    check("rst_cause", cause_o, 32'd0);
    check("rst_epc", epc_o, 32'd0);
    rd(5'd9, "rst_count", 32'd0);
    rd(5'd11, "rst_cmp", 32'd0);
    rd(5'd8, "rst_badv", 32'd0);
    rst = 1'b1;
    tick();
    rd(5'd9, "post_rst_count", 32'd1);
    check("post_rst_ti", {31'd0, cause_o[15]}, 32'd0);

    // EBase fixed bits and vector relocation
    mtc0(5'd15, 32'hFFFF_FFFF);
    rd(5'd15, "ebase_wr", 32'hBFFF_F000);
    exc_valid = 1'b1; exc_pc = 32'h8000_0500;
    tick();
    exc_valid = 1'b0;
    check("ebase_vec", redirect_pc, 32'hBFFF_F180);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
- Parametrised second-generation coprocessor-0 block. Holds the MIPS32 system registers: BadVAddr, Count, Compare, Status, Cause, EPC and EBase.
- Adds three things the first generation lacked: a Count/Compare timer, masked hardware-interrupt arbitration, and prioritised exception/ERET sequencing.
- Sits beside the MEM/WB boundary of the pipeline. It feeds the redirect target and the interrupt request back to the PC/flush logic.

Parameters:
- NUM_HW_INT, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2 +: NUM_HW_INT].
- COUNT_DIV, 1, Count increments once every COUNT_DIV cycles (1 or 2).
- STATUS_RST, 32'h1000_0000, Status reset value (CU0=1, IE=0, EXL=0).
- EBASE_RST, 32'h8000_0000, EBase reset value.
- EXC_OFFSET, 32'h0000_0180, general exception vector offset added to EBase.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 at a rising edge resets)
- raddr  in  5  CP0 register number for MFC0
- rdata  out  32  read data, combinational; 0 for unimplemented numbers
- we  in  1  MTC0 write enable
- waddr  in  5  MTC0 register number
- wdata  in  32  MTC0 data
- hw_int  in  NUM_HW_INT  level-sensitive external interrupts
- exc_valid  in  1  exception commit this cycle
- exc_code  in  5  ExcCode to record
- exc_pc  in  32  PC of the faulting instruction
- exc_bd  in  1  faulting instruction is in a delay slot
- exc_badvaddr  in  32  faulting address
- exc_badv_we  in  1  update BadVAddr (AdEL/AdES only)
- eret  in  1  ERET commit this cycle
- int_req  out  1  pending enabled interrupt
- redirect  out  1  pulse: fetch must jump to redirect_pc
- redirect_pc  out  32  exception vector or EPC
- status_o, cause_o, epc_o  out  32 each  register taps

Behaviour:
- Register numbers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 EBase. Writes to any other number are ignored.
- Reset values:
  - Status = STATUS_RST; EBase = EBASE_RST.
  - Count, Compare, Cause, EPC, BadVAddr = 0.
  - redirect = 0; the internal TI flag and the divider are cleared.
- Count:
  - Increments every COUNT_DIV cycles and wraps 0xFFFF_FFFF -> 0.
  - An MTC0 to Count loads wdata and restarts the divider; the increment is suppressed that cycle.
- Timer:
  - When Count == Compare and Compare != 0, the TI flag sets the cycle after the match.
  - TI is sticky. An MTC0 to Compare clears TI; clearing wins over a same-cycle match.
  - Cause.IP7 = TI OR hw_int[5] (hw_int[5] only exists when NUM_HW_INT == 6).
- Cause.IP[2 +: NUM_HW_INT]:
  - Sampled from hw_int every cycle, i.e. registered with 1-cycle latency.
  - Unused IP bits read 0.
- Writable fields:
  - Cause: only IP[1:0] (software interrupts).
  - Status: only IM[15:8], EXL[1] and IE[0]. Other bits keep their reset values.
  - EPC and EBase[29:12]: writable. EBase[31:30] = 2'b10 and EBase[11:0] = 0 are fixed.
  - BadVAddr and Count follow the rules above.
- int_req = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM). It is combinational from registered state.
- Priority when several events fall in the same cycle: exc_valid > eret > MTC0. A lower-priority event is dropped entirely.
- Exception entry (exc_valid):
  - If Status.EXL == 0: EPC = exc_bd ? exc_pc - 4 : exc_pc, and Cause.BD = exc_bd.
  - If Status.EXL == 1: EPC and BD are unchanged.
  - Always: EXL = 1, Cause.ExcCode = exc_code, BadVAddr = exc_badvaddr when exc_badv_we.
  - redirect = 1 for exactly the next cycle, with redirect_pc = EBase + EXC_OFFSET.
- ERET:
  - EXL = 0.
  - redirect = 1 for the next cycle, with redirect_pc = EPC (the value before any same-cycle update).
- Interrupt entry:
  - The pipeline raises exc_valid with code 0 upon seeing int_req. This block takes no extra action.
- Reset mid-operation:
  - Reset overrides every event in that cycle.
  - A pending redirect is cancelled, and TI and the divider are cleared.
- redirect is never high for two consecutive cycles unless a new exc_valid or eret arrives in each cycle.

Test Plan:
- Reset, then read regs 12, 13, 15 -> 0x1000_0000, 0, 0x8000_0000. Count = 3 after 3 cycles (COUNT_DIV = 1).
- MTC0 Compare = 10, MTC0 Count = 5 -> TI and Cause[15] set at Count == 11. MTC0 Compare = 20 clears Cause[15] the next cycle.
- Status = 0x0000_0401, hw_int[0] = 1 -> Cause[10] = 1 and int_req = 1 one cycle later. Setting EXL = 1 drops int_req to 0.
- exc_valid with code 8, pc 0x8000_0104, bd = 1 -> EPC = 0x8000_0100, Cause[31] = 1, Cause[6:2] = 8, EXL = 1. redirect = 1 next cycle with pc 0x8000_0180. A second exception while EXL = 1 leaves EPC unchanged.
- exc_valid, eret and MTC0 EPC all in the same cycle -> only the exception takes effect; EPC equals the exception value.
- rst low while TI = 1 and redirect is pending -> all registers at reset values next cycle, redirect = 0.
